// File: rtl/line_buffer_pkg.sv
// line_buffer_pkg: timing constants, FSM states and colour helper for the
// scanline ping-pong buffer (grid overlay gated by LB_DEBUG_GRID_EN).
package line_buffer_pkg;

  localparam int TILE_W    = 16;
  localparam int NUM_COLS  = 40;
  localparam int PIX_W     = 16;
  localparam int WORD_W    = TILE_W * PIX_W;
  localparam int RAM_DEPTH = 2 * NUM_COLS;
  localparam int HACTIVE   = 1280;
  localparam int HTOTAL    = 1600;
  localparam int VACTIVE   = 480;
  localparam int VTOTAL    = 525;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    READY
  } lb_state_t;

  typedef logic [PIX_W-1:0] rgb565_t;

  function automatic logic [23:0] rgb565_to_888(rgb565_t p);
    return {p[15:11], p[15:13],
            p[10:5],  p[10:9],
            p[4:0],   p[4:2]};
  endfunction

endpackage

// File: rtl/lb_bank_ram.sv
// lb_bank_ram: two banks of NUM_COLS tile-column words, one write port
// and one registered read port.
module lb_bank_ram
  import line_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic              wbank,
  input  logic [5:0]        wcol,
  input  logic [WORD_W-1:0] wdata,
  input  logic              rbank,
  input  logic [5:0]        rcol,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [RAM_DEPTH];

  function automatic logic [6:0] addr(logic bank, logic [5:0] col);
    return bank ? ({1'b0, col} + 7'(NUM_COLS)) : {1'b0, col};
  endfunction

  always_ff @(posedge clk) begin
    if (we) mem[addr(wbank, wcol)] <= wdata;
    rdata <= mem[addr(rbank, rcol)];
  end

endmodule

// File: rtl/line_buffer_reader.sv
// line_buffer_reader: ping-pong scanline buffer between tile_engine and VGA.
// Define LB_DEBUG_GRID_EN to overlay a magenta tile/line grid on the output.
module line_buffer_reader
  import line_buffer_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [10:0]  hcount,
  input  logic [9:0]   vcount,
  input  logic         blank_n_in,
  output logic         fill_start,
  output logic [9:0]   fill_line,
  input  logic         fill_done,
  input  logic         wr_en,
  input  logic [5:0]   wr_col,
  input  logic [255:0] wr_data,
  output logic [7:0]   pix_r,
  output logic [7:0]   pix_g,
  output logic [7:0]   pix_b,
  output logic         pix_blank_n,
  output logic         underrun,
  input  logic         underrun_clr
);

  localparam logic [10:0] H_FILL = 11'(HACTIVE);
  localparam logic [10:0] H_SWAP = 11'(HTOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(VTOTAL - 1);
  localparam logic [9:0]  V_ACT  = 10'(VACTIVE);
  localparam logic [5:0]  COLS   = 6'(NUM_COLS);

  lb_state_t state, state_d;

  logic              front_sel;
  logic [1:0]        bank_valid;
  logic [9:0]        next_line;
  logic [9:0]        line_q;
  logic              swap;
  logic              wr_accept;
  logic              toggle;
  logic              back_set;
  logic              front_clr;
  logic              underrun_set;
  logic [5:0]        rd_col;
  logic [WORD_W-1:0] rd_word;
  logic [3:0]        px_q;
  logic              blank_q;
  logic              valid_q;
  rgb565_t           px_word;
  logic [23:0]       rgb;

  assign next_line = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
  assign swap      = (hcount == H_SWAP);
  assign wr_accept = (state == FILL) && wr_en && (wr_col < COLS);
  assign fill_line = fill_start ? next_line : line_q;
  assign rd_col    = (hcount[10:5] < COLS) ? hcount[10:5] : 6'd0;

  always_comb begin
    state_d      = state;
    fill_start   = 1'b0;
    toggle       = 1'b0;
    back_set     = 1'b0;
    front_clr    = 1'b0;
    underrun_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (!reset && hcount == H_FILL && next_line < V_ACT) begin
          fill_start = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        if (swap) begin
          state_d = IDLE;
          // a fill_done landing on the swap cycle still completes the line
          if (fill_done) begin
            back_set = 1'b1;
            toggle   = 1'b1;
          end else begin
            front_clr    = 1'b1;
            underrun_set = 1'b1;
          end
        end else if (fill_done) begin
          back_set = 1'b1;
          state_d  = READY;
        end
      end
      READY: begin
        if (swap) begin
          toggle  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      front_sel  <= 1'b0;
      bank_valid <= 2'b00;
      line_q     <= 10'd0;
      underrun   <= 1'b0;
    end else begin
      state <= state_d;
      if (fill_start) line_q <= next_line;
      if (back_set) bank_valid[~front_sel] <= 1'b1;
      if (toggle || front_clr) bank_valid[front_sel] <= 1'b0;
      if (toggle) front_sel <= ~front_sel;
      if (underrun_set) underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

  lb_bank_ram u_ram (
    .clk   (clk),
    .we    (wr_accept),
    .wbank (~front_sel),
    .wcol  (wr_col),
    .wdata (wr_data),
    .rbank (front_sel),
    .rcol  (rd_col),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      px_q    <= 4'd0;
      blank_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      px_q    <= hcount[4:1];
      blank_q <= blank_n_in;
      valid_q <= bank_valid[front_sel];
    end
  end

`ifdef LB_DEBUG_GRID_EN
  logic [3:0] row_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) row_q <= 4'd0;
    else       row_q <= vcount[3:0];
  end
`endif

  always_comb begin
    px_word = rd_word[{px_q, 4'b0000} +: PIX_W];
    rgb     = rgb565_to_888(px_word);
`ifdef LB_DEBUG_GRID_EN
    if (px_q == 4'd0 || row_q == 4'd0) rgb = 24'hFF00FF;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_r       <= 8'd0;
      pix_g       <= 8'd0;
      pix_b       <= 8'd0;
      pix_blank_n <= 1'b0;
    end else begin
      pix_blank_n <= blank_q;
      if (blank_q && valid_q) {pix_r, pix_g, pix_b} <= rgb;
      else                    {pix_r, pix_g, pix_b} <= 24'd0;
    end
  end

endmodule

// File: tb/tb_line_buffer_reader.sv
// tb_line_buffer_reader: random line-by-line stimulus checked against a
// ping-pong scanline model (pixels, fill handshake, underrun, reset).
module tb_line_buffer_reader;

  logic         clk = 1'b0;
  logic         reset;
  logic [10:0]  hcount;
  logic [9:0]   vcount;
  logic         blank_n_in;
  logic         fill_start;
  logic [9:0]   fill_line;
  logic         fill_done;
  logic         wr_en;
  logic [5:0]   wr_col;
  logic [255:0] wr_data;
  logic [7:0]   pix_r, pix_g, pix_b;
  logic         pix_blank_n;
  logic         underrun;
  logic         underrun_clr;

  int n_chk  = 0;
  int n_fail = 0;

  logic [255:0] mem [2][40];
  bit   known [2][40];
  bit   valid [2];
  int   front;
  bit   filling, complete, m_underrun;
  bit   force_red;

  line_buffer_reader dut (
    .clk          (clk),
    .reset        (reset),
    .hcount       (hcount),
    .vcount       (vcount),
    .blank_n_in   (blank_n_in),
    .fill_start   (fill_start),
    .fill_line    (fill_line),
    .fill_done    (fill_done),
    .wr_en        (wr_en),
    .wr_col       (wr_col),
    .wr_data      (wr_data),
    .pix_r        (pix_r),
    .pix_g        (pix_g),
    .pix_b        (pix_b),
    .pix_blank_n  (pix_blank_n),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] model_pix(int h, bit bn);
    logic [255:0] w;
    logic [15:0]  q;
    int c, p;
    c = h / 32;
    p = (h / 2) % 16;
    if (!bn || !valid[front]) return 24'h0;
    w = mem[front][c];
    q = w[p*16 +: 16];
    return {q[15:11], q[15:13], q[10:5], q[10:9], q[4:0], q[4:2]};
  endfunction

  function automatic logic [255:0] rand_word();
    logic [255:0] w;
    for (int q = 0; q < 8; q++) w[q*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_pix"}, {8'h0, pix_r, pix_g, pix_b}, 32'h0);
    check({tag, "_blank_n"}, 32'(pix_blank_n), 32'h0);
    check({tag, "_fill_start"}, 32'(fill_start), 32'h0);
    check({tag, "_fill_line"}, 32'(fill_line), 32'h0);
    check({tag, "_underrun"}, 32'(underrun), 32'h0);
  endtask

  task automatic scan(input int v, input int n);
    logic [23:0] eq[$];
    bit bq[$];
    bit kq[$];
    int h;
    bit bn;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (eq.size() == 2 || (i >= n && eq.size() > 0)) begin
        logic [23:0] e;
        bit k, b;
        e = eq.pop_front();
        k = kq.pop_front();
        b = bq.pop_front();
        check("blank_n", 32'(pix_blank_n), 32'(b));
        if (k) check("pixel", {8'h0, pix_r, pix_g, pix_b}, {8'h0, e});
      end
      if (i < n) begin
        h  = (i == 0) ? 96 : int'($urandom_range(0, 1279));
        bn = (v < 480) && ($urandom_range(0, 7) != 0);
        vcount     = 10'(v);
        hcount     = 11'(h);
        blank_n_in = bn;
        eq.push_back(model_pix(h, bn));
        bq.push_back(bn);
        kq.push_back(!(bn && valid[front]) || known[front][h/32]);
      end
    end
  endtask

  // mode 0: done with last write, 1: withheld, 2: done on swap, 3: READY writes
  task automatic do_line(input int v, input int mode);
    int nl, b, n;
    bit req;
    int cols[$];
    scan(v, 24);
    nl  = (v == 524) ? 0 : v + 1;
    req = (nl < 480);
    @(negedge clk);
    vcount = 10'(v); hcount = 11'(1280); blank_n_in = 1'b0;
    #1;
    check("fill_start", 32'(fill_start), 32'(req));
    if (req) begin
      check("fill_line", 32'(fill_line), 32'(nl));
      filling  = 1;
      complete = 0;
    end
    b = 1 - front;
    for (int c = 0; c < 40; c++)
      if (force_red || $urandom_range(0, 9) != 0) cols.push_back(c);
    for (int k = 0; k < 3; k++) cols.push_back(int'($urandom_range(40, 63)));
    for (int k = 0; k < cols.size(); k++) begin
      int j = int'($urandom_range(0, cols.size() - 1));
      int t = cols[k];
      cols[k] = cols[j];
      cols[j] = t;
    end
    n = cols.size();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      hcount  = 11'(1281 + k);
      wr_en   = 1'b1;
      wr_col  = 6'(cols[k]);
      wr_data = rand_word();
      if (force_red && cols[k] == 3) wr_data[15:0] = 16'hF800;
      fill_done = (k == n - 1) && (mode == 0 || mode == 3);
      if (k == 0) begin
        #1;
        check("fill_start_pulse", 32'(fill_start), 32'h0);
      end
      if (filling && cols[k] < 40) begin
        mem[b][cols[k]]   = wr_data;
        known[b][cols[k]] = 1;
      end
      if (fill_done && filling) begin
        filling = 0; complete = 1; valid[b] = 1;
      end
    end
    if (mode == 3) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        hcount    = 11'(1400 + k);
        fill_done = 1'b0;
        wr_en     = 1'b1;
        wr_col    = 6'($urandom_range(0, 39));
        wr_data   = rand_word();
      end
    end
    @(negedge clk);
    hcount       = 11'(1599);
    wr_en        = 1'b0;
    fill_done    = (mode == 2);
    underrun_clr = (mode == 1);
    if (fill_done && filling) begin
      filling = 0; complete = 1; valid[b] = 1;
    end
    if (complete) begin
      valid[front] = 0; front = b; complete = 0;
    end else if (filling) begin
      valid[front] = 0; m_underrun = 1; filling = 0;
    end else if (underrun_clr) begin
      m_underrun = 0;
    end
    @(negedge clk);
    hcount       = 11'(0);
    vcount       = 10'(nl);
    underrun_clr = 1'b0;
    fill_done    = (mode == 1);
    wr_en        = (mode == 1);
    wr_col       = 6'd0;
    wr_data      = rand_word();
    check("underrun_swap", 32'(underrun), 32'(m_underrun));
    @(negedge clk);
    fill_done = 1'b0;
    wr_en     = 1'b0;
    check("underrun_late", 32'(underrun), 32'(m_underrun));
    if (mode == 1) begin
      underrun_clr = 1'b1;
      m_underrun   = 0;
      @(negedge clk);
      underrun_clr = 1'b0;
      check("underrun_clr", 32'(underrun), 32'(m_underrun));
    end
  endtask

  initial begin
    reset = 1'b1; hcount = '0; vcount = '0; blank_n_in = 1'b0;
    fill_done = 1'b0; wr_en = 1'b0; wr_col = '0; wr_data = '0;
    underrun_clr = 1'b0;
    front = 0; valid[0] = 0; valid[1] = 0;
    filling = 0; complete = 0; m_underrun = 0; force_red = 0;
    for (int bk = 0; bk < 2; bk++)
      for (int c = 0; c < 40; c++) known[bk][c] = 0;

    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    force_red = 1;
    do_line(524, 0);
    force_red = 0;
    @(negedge clk);
    vcount = 10'd0; hcount = 11'd96; blank_n_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("red96", {8'h0, pix_r, pix_g, pix_b}, 32'h00FF0000);
    check("red96_blank_n", 32'(pix_blank_n), 32'h1);

    for (int v = 0; v < 14; v++) do_line(v, v % 4);
    for (int k = 0; k < 10; k++)
      do_line(int'($urandom_range(0, 523)), int'($urandom_range(0, 3)));
    do_line(478, 0);
    do_line(479, 0);
    do_line(480, 3);
    do_line(523, 0);
    do_line(524, 2);
    do_line(0, 0);

    @(negedge clk);
    vcount = 10'd200; hcount = 11'd1280; blank_n_in = 1'b0;
    #1;
    check("rst_fill_start", 32'(fill_start), 32'h1);
    filling = 1;
    @(negedge clk);
    hcount = 11'd600; blank_n_in = 1'b1;
    wr_en = 1'b1; wr_col = 6'd5; wr_data = rand_word();
    mem[1-front][5] = wr_data;
    known[1-front][5] = 1;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle("rst_mid");
    front = 0; valid[0] = 0; valid[1] = 0;
    filling = 0; complete = 0; m_underrun = 0;
    @(negedge clk);
    reset = 1'b0; hcount = 11'd601;
    @(negedge clk);
    check("rst_no_start", 32'(fill_start), 32'h0);
    do_line(100, 0);
    do_line(101, 1);
    do_line(102, 0);
    do_line(103, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/line_buffer_reader.md
Name: line_buffer_reader

Overview:
- Consumer side of the tile_engine scanline interface.
- Owns a ping-pong pair of scanline buffers. Each buffer holds 40 tile columns × 16 px × 16-bit RGB565.
- Requests the fill of the next line during horizontal blanking and accepts tile writes into the back bank.
- Reads the front bank in step with hcount/vcount and drives 24-bit RGB to the VGA output mux in vga_top.

Parameters:
- TILE_W, 16, pixels per tile column (power of 2).
- NUM_COLS, 40, tile columns per line (640/16).
- PIX_W, 16, bits per pixel, RGB565.
- HACTIVE, 1280, active hcount range (2 clk per pixel).
- HTOTAL, 1600, hcount period.
- VACTIVE, 480, active lines.
- VTOTAL, 525, vcount period.

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-high.
- hcount  in  11  from vga_counters; hcount[10:1] is the pixel column.
- vcount  in  10  from vga_counters.
- blank_n_in  in  1  VGA_BLANK_n from vga_counters.
- fill_start  out  1  one-cycle pulse: begin filling fill_line.
- fill_line  out  10  line number the writer must render.
- fill_done  in  1  one-cycle pulse: all columns for fill_line written.
- wr_en  in  1  tile column write strobe.
- wr_col  in  6  tile column index, 0..NUM_COLS-1.
- wr_data  in  256  16 px; pixel 0 (leftmost) in [15:0], pixel 15 in [255:240].
- pix_r, pix_g, pix_b  out  8 each  pixel colour.
- pix_blank_n  out  1  blank_n_in delayed to match pixel latency.
- underrun  out  1  sticky: a bank swap occurred with the fill incomplete.
- underrun_clr  in  1  clears underrun.

Behaviour:
- Reset state: all outputs 0; FSM in IDLE; both banks marked invalid; front bank select = 0.
- FSM has three states: IDLE, FILL, READY.
  - IDLE -> FILL when hcount == HACTIVE and next_line < VACTIVE. In that cycle fill_start=1 and fill_line=next_line.
  - next_line = vcount+1, or 0 when vcount == VTOTAL-1. Consequence: line 0 is requested during the hblank of line 524; lines 480..523 issue no request.
  - FILL -> READY on fill_done; back bank marked valid.
  - READY -> IDLE on the swap cycle.
- Swap cycle is hcount == HTOTAL-1.
  - If FSM is READY: toggle front select; the new back bank becomes invalid.
  - If FSM is FILL: no toggle; set underrun; front bank marked invalid; FSM -> IDLE. A fill_done arriving later is ignored.
  - If FSM is IDLE: nothing happens.
- Writes:
  - Accepted only in FILL and only when wr_col < NUM_COLS; they go to the back bank.
  - Writes in IDLE/READY or with wr_col >= NUM_COLS are dropped.
  - A write in the same cycle as fill_done is accepted.
- Simultaneous events:
  - fill_done on the swap cycle counts as complete: the swap toggles and no underrun is raised.
  - underrun_clr together with a new underrun: set wins.
- Read pipeline, 2 clk latency:
  - Stage 1: col = hcount[10:5], px = hcount[4:1]; read front-bank word at col.
  - Stage 2: select the 16-bit pixel px, expand RGB565 to RGB888 by MSB replication (r8 = {r5, r5[4:2]}, g8 = {g6, g6[5:4]}, b8 = {b5, b5[4:2]}), and register it.
- pix_blank_n is blank_n_in delayed 2 clk. RGB output is forced to 0 when the delayed blank_n is 0 or the front bank is invalid.
- Storage: inferred as 2×40×256-bit RAM with one write port and one synchronous read port.
- Reset mid-fill: FSM returns to IDLE, banks become invalid, and the next request occurs at the next qualifying hblank.

Optional Feature:
- Macro: LB_DEBUG_GRID_EN.
- Defined: a pixel with px == 0, or with a line number whose low 4 bits are 0, outputs 24'hFF00FF instead of buffer data. The line number is vcount delayed through the pipeline. Blanking and invalid-bank forcing still take priority.
- Undefined: no grid logic is synthesised; output is buffer data only.

Decomposition:
- Package line_buffer_pkg:
  - timing constants HACTIVE, HTOTAL, VACTIVE, VTOTAL, TILE_W, NUM_COLS;
  - typedef enum lb_state_t {IDLE, FILL, READY};
  - typedef logic [15:0] rgb565_t;
  - function rgb565_to_888.
- One sub-module: lb_bank_ram, the dual-bank 256-bit-wide simple dual-port RAM with registered read.

Test Plan:
- Reset release, vcount=524, hcount reaches 1280 -> fill_start pulses for 1 clk with fill_line=0 and the FSM enters FILL; pix_* stay 0 until line 0 is valid.
- Fill line 0 with wr_col=3 and wr_data[15:0]=16'hF800 (pixel 0), then fill_done, then the swap at hcount=1599 -> 2 clk after hcount=96 on line 0, pix_r=8'hFF, pix_g=0, pix_b=0 with pix_blank_n=1.
- Withhold fill_done through hcount=1599 -> underrun=1, next line outputs 0; a later fill_done is ignored; underrun_clr pulse -> underrun=0.
- wr_en with wr_col=40 during FILL, and wr_en during READY -> buffer contents unchanged (readback of cols 0..39 matches the prior pattern).
- fill_done on the exact cycle hcount=1599 -> swap occurs, underrun stays 0.
- Assert reset while in FILL at hcount=600 -> all outputs 0 immediately; after release the next fill_start occurs at the next hcount=1280 with the correct fill_line.
